mem_ddr_loader: RTL and testbench

- Upstream feeder of the memory farm's DDR-to-SRAM load path.
- Accepts a software load command (DDR source address, SRAM destination, byte count) and issues line-sized (32 B) DDR read requests with credit-based flow control.
- Buffers returned lines in a small in-order FIFO and streams them to the farm demux as valid/data/last/num_of_last_valid beats.
- Honours demux_busy backpressure from the demux.

---
 rtl/mem_ddr_loader.sv | 179 +++++++++++++++++
 tb/tb_mem_ddr_loader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ddr_loader.sv
// DDR-to-SRAM load feeder: splits a load command into line-sized DDR reads under a credit
// limit, buffers returned lines in order and streams them to the memory-farm demux.
module mem_ddr_loader #(
    parameter int unsigned LINE_BYTES  = 32,
    parameter int unsigned DDR_ADDR_W  = 32,
    parameter int unsigned SRAM_ADDR_W = 19,
    parameter int unsigned LEN_W       = 19,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [DDR_ADDR_W-1:0]         cmd_ddr_addr,
    input  logic [SRAM_ADDR_W-1:0]        cmd_sram_addr,
    input  logic [LEN_W-1:0]              cmd_num_bytes,
    output logic                          ddr_req,
    output logic [DDR_ADDR_W-1:0]         ddr_addr,
    input  logic                          ddr_gnt,
    input  logic                          ddr_valid,
    input  logic [8*LINE_BYTES-1:0]       ddr_data,
    output logic                          out_valid,
    output logic [8*LINE_BYTES-1:0]       out_data,
    output logic [SRAM_ADDR_W-1:0]        out_base_addr,
    output logic                          out_last,
    output logic [$clog2(LINE_BYTES)-1:0] out_num_of_last_valid,
    input  logic                          demux_busy,
    output logic                          busy,
    output logic                          done,
    output logic                          err_unexp
);

    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned DATA_W = 8 * LINE_BYTES;
    localparam int unsigned LINE_W = LEN_W - OFF_W + 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [LINE_W-1:0]      lines_q, lines_d, issue_cnt_q, issue_cnt_d, pop_cnt_q, pop_cnt_d;
    logic [OFF_W-1:0]       rem_q, rem_d;
    logic [DDR_ADDR_W-1:0]  base_q, base_d;
    logic [SRAM_ADDR_W-1:0] sram_q, sram_d;
    logic [CNT_W-1:0]       outst_q, outst_d, count_q, count_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]      mem_d [FIFO_DEPTH];
    logic                   err_q, err_d;

    logic [LEN_W:0]         bytes_rnd;
    logic [LINE_W-1:0]      lines_calc;
    logic                   accept, grant, push, stray, pop, credit_ok;

    assign bytes_rnd  = {1'b0, cmd_num_bytes} + (LEN_W + 1)'(LINE_BYTES - 1);
    assign lines_calc = LINE_W'(bytes_rnd >> OFF_W);

    assign accept = cmd_valid && cmd_ready;
    assign grant  = ddr_req && ddr_gnt;
    assign push   = ddr_valid && (outst_q != '0);
    assign stray  = ddr_valid && (outst_q == '0);
    assign pop    = out_valid && !demux_busy;

    // Lines in flight plus lines buffered never exceed the FIFO, so returns always fit.
    assign credit_ok = ({1'b0, outst_q} + {1'b0, count_q}) < (CNT_W + 1)'(FIFO_DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = (lines_calc == '0) ? StDone : StFetch;
            StFetch: if (grant && (issue_cnt_q + LINE_W'(1) == lines_q)) state_d = StDrain;
            StDrain: if (pop_cnt_q == lines_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == StIdle) && !rst;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        ddr_req   = (state_q == StFetch) && (issue_cnt_q < lines_q) && credit_ok;
    end

    always_comb begin
        lines_d     = lines_q;
        rem_d       = rem_q;
        base_d      = base_q;
        sram_d      = sram_q;
        issue_cnt_d = issue_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        outst_d     = outst_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_d       = mem_q;
        err_d       = err_q;

        if (accept) begin
            lines_d     = lines_calc;
            rem_d       = cmd_num_bytes[OFF_W-1:0];
            base_d      = cmd_ddr_addr & ~DDR_ADDR_W'(LINE_BYTES - 1);
            sram_d      = cmd_sram_addr;
            issue_cnt_d = '0;
            pop_cnt_d   = '0;
            err_d       = 1'b0;
        end
        if (grant) issue_cnt_d = issue_cnt_q + LINE_W'(1);
        if (pop) begin
            pop_cnt_d = pop_cnt_q + LINE_W'(1);
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            mem_d[wr_ptr_q] = ddr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (stray) err_d = 1'b1;

        case ({grant, push})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lines_q     <= '0;
            rem_q       <= '0;
            base_q      <= '0;
            sram_q      <= '0;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            outst_q     <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_q       <= '{default: '0};
            err_q       <= 1'b0;
        end else begin
            lines_q     <= lines_d;
            rem_q       <= rem_d;
            base_q      <= base_d;
            sram_q      <= sram_d;
            issue_cnt_q <= issue_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            outst_q     <= outst_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
            err_q       <= err_d;
        end
    end

    assign ddr_addr              = base_q + DDR_ADDR_W'({issue_cnt_q, {OFF_W{1'b0}}});
    assign out_valid             = (count_q != '0);
    assign out_data              = mem_q[rd_ptr_q];
    assign out_last              = out_valid && (pop_cnt_q == lines_q - LINE_W'(1));
    assign out_num_of_last_valid = rem_q;
    assign out_base_addr         = sram_q;
    assign err_unexp             = err_q;

endmodule

// File: tb/tb_mem_ddr_loader.sv
// Directed bench for mem_ddr_loader: a DDR responder returns {8{line address}} per grant,
// and a monitor records grants and consumed beats for comparison against hand values.
module tb_mem_ddr_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [31:0]  cmd_ddr_addr;
    logic [18:0]  cmd_sram_addr, cmd_num_bytes;
    logic         ddr_req, ddr_gnt, ddr_valid;
    logic [31:0]  ddr_addr;
    logic [255:0] ddr_data;
    logic         out_valid, out_last, demux_busy, busy, done, err_unexp;
    logic [255:0] out_data;
    logic [18:0]  out_base_addr;
    logic [4:0]   out_nlv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_ddr_loader dut (
        .clk                   (clk),
        .rst                   (rst),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_ddr_addr          (cmd_ddr_addr),
        .cmd_sram_addr         (cmd_sram_addr),
        .cmd_num_bytes         (cmd_num_bytes),
        .ddr_req               (ddr_req),
        .ddr_addr              (ddr_addr),
        .ddr_gnt               (ddr_gnt),
        .ddr_valid             (ddr_valid),
        .ddr_data              (ddr_data),
        .out_valid             (out_valid),
        .out_data              (out_data),
        .out_base_addr         (out_base_addr),
        .out_last              (out_last),
        .out_num_of_last_valid (out_nlv),
        .demux_busy            (demux_busy),
        .busy                  (busy),
        .done                  (done),
        .err_unexp             (err_unexp)
    );

    // DDR responder: in-order returns, lat cycles after each grant.
    int unsigned  lat = 1;
    int unsigned  cyc = 0;
    int unsigned  rq_due[$];
    logic [31:0]  rq_addr[$];
    logic         r_valid = 1'b0, s_valid = 1'b0;
    logic [255:0] r_data = '0, s_data = '0;

    assign ddr_valid = r_valid | s_valid;
    assign ddr_data  = r_valid ? r_data : s_data;

    always @(posedge clk) begin
        if (rst) begin
            rq_due.delete();
            rq_addr.delete();
        end else if (ddr_req && ddr_gnt) begin
            rq_due.push_back(cyc + lat);
            rq_addr.push_back(ddr_addr);
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        r_valid = 1'b0;
        if (!rst && rq_due.size() > 0 && rq_due[0] <= cyc) begin
            r_data  = {8{rq_addr[0]}};
            r_valid = 1'b1;
            void'(rq_due.pop_front());
            void'(rq_addr.pop_front());
        end
    end

    // Monitor
    logic [31:0]  g_addr[$];
    logic [255:0] b_data[$];
    logic         b_last[$];
    logic [4:0]   b_nlv[$];
    logic [18:0]  b_base[$];
    int           inflight = 0;
    int           max_inflight = 0;
    int           done_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            inflight <= 0;
        end else begin
            if (ddr_req && ddr_gnt) g_addr.push_back(ddr_addr);
            if (out_valid && !demux_busy) begin
                b_data.push_back(out_data);
                b_last.push_back(out_last);
                b_nlv.push_back(out_nlv);
                b_base.push_back(out_base_addr);
            end
            inflight <= inflight + int'(ddr_req && ddr_gnt) - int'(out_valid && !demux_busy);
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (inflight > max_inflight) max_inflight <= inflight;
    end

    function automatic logic [255:0] pat(input logic [31:0] a);
        return {8{a}};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        g_addr.delete();
        b_data.delete();
        b_last.delete();
        b_nlv.delete();
        b_base.delete();
    endtask

    task automatic send_cmd(input string tag, input logic [31:0] a, input logic [18:0] s,
                            input logic [18:0] n);
        int k = 0;
        cmd_valid     = 1'b1;
        cmd_ddr_addr  = a;
        cmd_sram_addr = s;
        cmd_num_bytes = n;
        while (cmd_ready !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({tag, " accept"}, cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({tag, " done"}, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] cap;
        bit           cap_ok, stable;
        int           d0, k;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_ddr_addr = '0; cmd_sram_addr = '0; cmd_num_bytes = '0;
        ddr_gnt = 1'b1; demux_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst cmd_ready", cmd_ready, 0);
        check("rst busy", busy, 0);
        check("rst ddr_req", ddr_req, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst err", err_unexp, 0);
        check("rst done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle cmd_ready", cmd_ready, 1);

        // Single line; request held without grant must stay stable.
        clear_mon();
        ddr_gnt = 1'b0;
        send_cmd("t1", 32'h1000, 19'h40, 19'd32);
        check("t1 req", ddr_req, 1);
        check("t1 addr", ddr_addr, 32'h1000);
        repeat (3) @(negedge clk);
        check("t1 req held", ddr_req, 1);
        check("t1 addr held", ddr_addr, 32'h1000);
        ddr_gnt = 1'b1;
        wait_done("t1");
        check("t1 beats at done", b_data.size(), 1);
        check("t1 grants", g_addr.size(), 1);
        check("t1 data", b_data[0], pat(32'h1000));
        check("t1 last", b_last[0], 1);
        check("t1 nlv", b_nlv[0], 0);
        check("t1 base", b_base[0], 19'h40);
        check("t1 busy in done", busy, 1);
        check("t1 ready in done", cmd_ready, 0);
        @(negedge clk);
        check("t1 done pulse", done, 0);
        check("t1 idle", cmd_ready, 1);

        // 100 bytes from unaligned address.
        clear_mon();
        send_cmd("t2", 32'h2007, 19'h80, 19'd100);
        wait_done("t2");
        check("t2 grants", g_addr.size(), 4);
        check("t2 beats", b_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2 gaddr%0d", i), g_addr[i], 32'h2000 + 32 * i);
            check($sformatf("t2 data%0d", i), b_data[i], pat(32'h2000 + 32 * i));
            check($sformatf("t2 last%0d", i), b_last[i], (i == 3) ? 1 : 0);
        end
        check("t2 nlv", b_nlv[3], 4);
        @(negedge clk);

        // 320 bytes under a 30-cycle stall with 2-cycle DDR latency.
        clear_mon();
        lat = 2;
        demux_busy = 1'b1;
        send_cmd("t3", 32'h10000, 19'h100, 19'd320);
        cap = '0; cap_ok = 1'b0; stable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (!cap_ok) begin
                    cap = out_data;
                    cap_ok = 1'b1;
                end else if (out_data !== cap) begin
                    stable = 1'b0;
                end
            end else if (cap_ok) begin
                stable = 1'b0;
            end
        end
        check("t3 grants in stall", g_addr.size(), 4);
        check("t3 beats in stall", b_data.size(), 0);
        check("t3 valid in stall", cap_ok, 1);
        check("t3 head data", cap, pat(32'h10000));
        check("t3 stable", stable, 1);
        demux_busy = 1'b0;
        wait_done("t3");
        check("t3 beats", b_data.size(), 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t3 data%0d", i), b_data[i], pat(32'h10000 + 32 * i));
        end
        check("t3 last", b_last[9], 1);
        check("t3 not last", b_last[8], 0);
        check("t3 nlv", b_nlv[9], 0);
        check("t3 max inflight", max_inflight <= 4, 1);
        lat = 1;
        @(negedge clk);

        // Zero length.
        clear_mon();
        send_cmd("t4", 32'h3000, 19'h10, 19'd0);
        check("t4 done", done, 1);
        check("t4 ready low", cmd_ready, 0);
        check("t4 req", ddr_req, 0);
        @(negedge clk);
        check("t4 done clr", done, 0);
        check("t4 ready back", cmd_ready, 1);
        check("t4 grants", g_addr.size(), 0);

        // Reset mid-transfer, stray return, recovery.
        clear_mon();
        send_cmd("t5", 32'h3000, 19'h200, 19'd128);
        k = 0;
        while (b_data.size() < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t5 two beats", b_data.size(), 2);
        rst = 1'b1;
        @(negedge clk);
        check("t5 rst busy", busy, 0);
        check("t5 rst valid", out_valid, 0);
        check("t5 rst req", ddr_req, 0);
        check("t5 rst data", out_data, 0);
        check("t5 rst last", out_last, 0);
        check("t5 rst ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        s_data = pat(32'hdead_beef);
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        check("t5 err set", err_unexp, 1);
        check("t5 stray dropped", out_valid, 0);
        clear_mon();
        send_cmd("t5b", 32'h4000, 19'h300, 19'd64);
        check("t5 err clr", err_unexp, 0);
        wait_done("t5b");
        check("t5 beats", b_data.size(), 2);
        check("t5 data0", b_data[0], pat(32'h4000));
        check("t5 data1", b_data[1], pat(32'h4020));
        @(negedge clk);

        // Back-to-back 64 B then 33 B.
        clear_mon();
        d0 = done_cnt;
        send_cmd("t6a", 32'h5000, 19'h400, 19'd64);
        send_cmd("t6b", 32'h6000, 19'h500, 19'd33);
        check("t6 accept after done", done_cnt, d0 + 1);
        wait_done("t6");
        check("t6 beats", b_data.size(), 4);
        check("t6 data0", b_data[0], pat(32'h5000));
        check("t6 data1", b_data[1], pat(32'h5020));
        check("t6 data2", b_data[2], pat(32'h6000));
        check("t6 data3", b_data[3], pat(32'h6020));
        check("t6 lasts", {b_last[0], b_last[1], b_last[2], b_last[3]}, 4'b0101);
        check("t6 nlv a", b_nlv[1], 0);
        check("t6 nlv b", b_nlv[3], 1);
        check("t6 base b", b_base[3], 19'h500);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
